// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus shared by the NREQ requesters of regfile_wr_arbiter.
// master = requester side, slave = arbiter side.
interface regfile_wr_arbiter_if #(
    parameter int n    = 16,
    parameter int r    = 3,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ*r-1:0] req_addr;
    logic [NREQ*n-1:0] req_data;

    modport master (
        output req_valid, req_addr, req_data, req_lock,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_lock,
        output req_ready
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port with a one-cycle output stage
// and read-after-write hazard flags. Optional burst lock: define RF_ARB_LOCK_EN.
module regfile_wr_arbiter #(
    parameter int n    = 16,
    parameter int r    = 3,
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    regfile_wr_arbiter_if.slave      req,
    output logic                     we3,
    output logic [r-1:0]             wa3,
    output logic [n-1:0]             wd3,
    output logic [$clog2(NREQ)-1:0]  wr_id,
    input  logic [r-1:0]             ra1,
    input  logic [r-1:0]             ra2,
    output logic                     hazard1,
    output logic                     hazard2
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;
    logic           found;
    logic           locked;
    logic [r-1:0]   sel_addr;
    logic [n-1:0]   sel_data;
    logic           we3_q;
    int unsigned    idx;

`ifdef RF_ARB_LOCK_EN
    logic           last_vld;
    logic [IDW-1:0] last_id;
`else
    logic           unused_lock;
    assign unused_lock = ^req.req_lock;
`endif

    always_comb begin
        gnt_id        = '0;
        cand          = '0;
        idx           = 0;
        found         = 1'b0;
        locked        = 1'b0;
        req.req_ready = '0;
        if (!reset && !hold) begin
`ifdef RF_ARB_LOCK_EN
            if (last_vld && req.req_lock[last_id] && req.req_valid[last_id]) begin
                found  = 1'b1;
                locked = 1'b1;
                gnt_id = last_id;
            end
`endif
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = ptr + k;
                if (idx >= NREQ) idx = idx - NREQ;
                cand = IDW'(idx);
                if (!found && req.req_valid[cand]) begin
                    found  = 1'b1;
                    gnt_id = cand;
                end
            end
            if (found) req.req_ready[gnt_id] = 1'b1;
        end
    end

    assign sel_addr = req.req_addr[gnt_id*r +: r];
    assign sel_data = req.req_data[gnt_id*n +: n];

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q <= 1'b0;
            wa3   <= '0;
            wd3   <= '0;
            wr_id <= '0;
            ptr   <= '0;
`ifdef RF_ARB_LOCK_EN
            last_vld <= 1'b0;
            last_id  <= '0;
`endif
        end else begin
            // Writes to register 0 are acknowledged but never reach the file.
            we3_q <= found && (sel_addr != '0);
            if (found) begin
                wa3   <= sel_addr;
                wd3   <= sel_data;
                wr_id <= gnt_id;
                if (!locked) ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
`ifdef RF_ARB_LOCK_EN
            last_vld <= found;
            last_id  <= gnt_id;
`endif
        end
    end

    // Reset masks the output stage immediately so an in-flight write never lands.
    assign we3     = we3_q && !reset;
    assign hazard1 = we3 && (ra1 == wa3) && (ra1 != '0);
    assign hazard2 = we3 && (ra2 == wa3) && (ra2 != '0);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (NREQ=2); expectations follow RF_ARB_LOCK_EN when defined.
module tb_regfile_wr_arbiter;
    localparam int N  = 16;
    localparam int R  = 3;
    localparam int NQ = 2;

    logic         clk = 1'b0;
    logic         reset, hold;
    logic         we3;
    logic [R-1:0] wa3, ra1, ra2;
    logic [N-1:0] wd3;
    logic         wr_id;
    logic         hazard1, hazard2;

    regfile_wr_arbiter_if #(.n(N), .r(R), .NREQ(NQ)) bus ();

    regfile_wr_arbiter #(.n(N), .r(R), .NREQ(NQ)) dut (
        .clk(clk), .reset(reset), .hold(hold), .req(bus.slave),
        .we3(we3), .wa3(wa3), .wd3(wd3), .wr_id(wr_id),
        .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [R-1:0] a;
        logic [N-1:0] d;
        logic         id;
        logic         rst;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    logic       mptr;
    logic       mlast_vld;
    logic       mlast;
    logic [1:0] rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check grant, push expectation, compare after posedge.
    task automatic cyc(input logic [1:0] v, input logic [R-1:0] a0, input logic [N-1:0] d0,
                       input logic [R-1:0] a1, input logic [N-1:0] d1,
                       input logic [1:0] lk, input logic h, input logic rs,
                       output logic [1:0] ready_obs);
        logic [1:0] eg;
        logic       gid;
        logic       got;
        logic       lkd;
        exp_t       e, o;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        bus.req_lock  = lk;
        hold  = h;
        reset = rs;
        #1;
        eg = 2'b00; got = 1'b0; lkd = 1'b0; gid = 1'b0;
        if (!rs && !h) begin
`ifdef RF_ARB_LOCK_EN
            if (mlast_vld && lk[mlast] && v[mlast]) begin got = 1'b1; lkd = 1'b1; gid = mlast; end
`endif
            if (!got && v[mptr])  begin got = 1'b1; gid = mptr;  end
            if (!got && v[~mptr]) begin got = 1'b1; gid = ~mptr; end
            if (got) eg[gid] = 1'b1;
        end
        ready_obs = bus.req_ready;
        chk("req_ready", {30'b0, bus.req_ready}, {30'b0, eg});
        if (rs) chk("we3_masked_in_reset", {31'b0, we3}, 32'd0);
        e.rst = rs;
        e.we  = got && ((gid ? a1 : a0) != '0);
        e.a   = gid ? a1 : a0;
        e.d   = gid ? d1 : d0;
        e.id  = gid;
        q.push_back(e);
        if (rs) begin
            mptr = 1'b0; mlast_vld = 1'b0; mlast = 1'b0;
        end else begin
            if (got && !lkd) mptr = ~gid;
            mlast_vld = got;
            mlast     = gid;
        end
        @(posedge clk);
        #1;
        o = q.pop_front();
        chk("we3", {31'b0, we3}, {31'b0, o.we && !o.rst});
        if (o.rst) begin
            chk("wa3_rst", {29'b0, wa3}, 32'd0);
            chk("wd3_rst", {16'b0, wd3}, 32'd0);
            chk("wr_id_rst", {31'b0, wr_id}, 32'd0);
        end else if (o.we) begin
            chk("wa3", {29'b0, wa3}, {29'b0, o.a});
            chk("wd3", {16'b0, wd3}, {16'b0, o.d});
            chk("wr_id", {31'b0, wr_id}, {31'b0, o.id});
        end
    endtask

    initial begin
        mptr = 1'b0; mlast_vld = 1'b0; mlast = 1'b0;
        ra1 = 3'd5; ra2 = 3'd3;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_lock = '0;
        hold = 1'b0; reset = 1'b1;

        // Reset then idle
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, rdy);
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, rdy);
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);
        chk("hazard1_idle", {31'b0, hazard1}, 32'd0);
        chk("hazard2_idle", {31'b0, hazard2}, 32'd0);

        // Single requester plus hazard probing while the write is in flight
        cyc(2'b01, 3'd5, 16'hBEEF, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);
        chk("single_grant", {30'b0, rdy}, 32'd1);
        ra1 = 3'd5; ra2 = 3'd0; #1;
        chk("hazard1_hit", {31'b0, hazard1}, 32'd1);
        chk("hazard2_zero_addr", {31'b0, hazard2}, 32'd0);
        ra1 = 3'd4; ra2 = 3'd5; #1;
        chk("hazard1_miss", {31'b0, hazard1}, 32'd0);
        chk("hazard2_hit", {31'b0, hazard2}, 32'd1);
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);
        chk("hazard2_after_drain", {31'b0, hazard2}, 32'd0);

        // Round robin from ptr=0
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 3'd1, 16'h1111 + 16'(i), 3'd2, 16'h2222 + 16'(i), 2'b00, 1'b0, 1'b0, rdy);
            chk("rr_grant", {30'b0, rdy}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Hold, then a register-0 write that is acked but dropped
        cyc(2'b11, 3'd1, 16'hAAAA, 3'd2, 16'hBBBB, 2'b00, 1'b1, 1'b0, rdy);
        cyc(2'b10, 3'd0, 16'h0, 3'd0, 16'hCCCC, 2'b00, 1'b0, 1'b0, rdy);
        chk("reg0_grant", {30'b0, rdy}, 32'd2);
        cyc(2'b11, 3'd6, 16'h6666, 3'd7, 16'h7777, 2'b00, 1'b0, 1'b0, rdy);
        chk("ptr_after_reg0", {30'b0, rdy}, 32'd1);

        // Mid-transfer reset: write to r3 must be squashed
        cyc(2'b01, 3'd3, 16'h1234, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, rdy);
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);

        // Lock sequence
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 3'd4, 16'h4000 + 16'(i), 3'd5, 16'h5000 + 16'(i),
                (i < 3) ? 2'b01 : 2'b00, 1'b0, 1'b0, rdy);
`ifdef RF_ARB_LOCK_EN
            chk("lock_grant", {30'b0, rdy}, (i < 3) ? 32'd1 : 32'd2);
`else
            chk("nolock_grant", {30'b0, rdy}, (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
        end
        cyc(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, rdy);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
